// File: rtl/prbs_checker.sv
// prbs_checker: self-synchronising checker for the 8-bit LFSR byte stream (x^8+x^6+x^5+x^4+1); ports: clk, rst (async active-low), in_valid/in_data byte input, clear zeroes err_count, locked/err_pulse/err_count/sync_state status
module prbs_checker #(
  parameter int LOCK_COUNT   = 4,
  parameter int UNLOCK_COUNT = 3,
  parameter int ERR_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [7:0]       in_data,
  input  logic             clear,
  output logic             locked,
  output logic             err_pulse,
  output logic [ERR_W-1:0] err_count,
  output logic [1:0]       sync_state
);
  typedef enum logic [1:0] {HUNT = 2'd0, VERIFY = 2'd1, LOCKED = 2'd2} state_t;
  state_t state, state_n;
  logic [7:0] pred, pred_n, step_d, step_p;
  logic [3:0] match_cnt, match_n, match_inc, miss_cnt, miss_n, miss_inc;
  logic hit, zero, err_n;
  logic [ERR_W-1:0] count_n;
  assign step_d    = {in_data[6:0], in_data[7] ^ in_data[5] ^ in_data[4] ^ in_data[3]};
  assign step_p    = {pred[6:0], pred[7] ^ pred[5] ^ pred[4] ^ pred[3]};
  assign hit       = in_data == pred;
  assign zero      = in_data == 8'h00;
  assign match_inc = match_cnt + 4'd1;
  assign miss_inc  = miss_cnt + 4'd1;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state     <= HUNT;
      pred      <= 8'h00;
      match_cnt <= '0;
      miss_cnt  <= '0;
      err_pulse <= 1'b0;
      err_count <= '0;
    end else begin
      state     <= state_n;
      pred      <= pred_n;
      match_cnt <= match_n;
      miss_cnt  <= miss_n;
      err_pulse <= err_n;
      err_count <= count_n;
    end
  always_comb begin
    state_n = state;
    pred_n  = pred;
    match_n = match_cnt;
    miss_n  = miss_cnt;
    if (in_valid)
      case (state)
        HUNT:
          if (!zero) begin
            state_n = VERIFY;
            pred_n  = step_d;
            match_n = '0;
          end
        VERIFY:
          if (zero) state_n = HUNT;
          else if (hit) begin
            pred_n  = step_d;
            match_n = match_inc;
            if (match_inc == 4'(LOCK_COUNT)) begin
              state_n = LOCKED;
              miss_n  = '0;
            end
          end else begin
            pred_n  = step_d;
            match_n = '0;
          end
        LOCKED: begin
          pred_n = step_p;
          miss_n = hit ? '0 : miss_inc;
          if (!hit && miss_inc == 4'(UNLOCK_COUNT)) state_n = HUNT;
        end
        default: state_n = HUNT;
      endcase
  end
  always_comb begin
    err_n   = in_valid && state == LOCKED && !hit;
    count_n = clear ? '0 : (err_n && !(&err_count)) ? err_count + ERR_W'(1) : err_count;
  end
  assign locked     = state == LOCKED;
  assign sync_state = state;
endmodule
